// File: rtl/jtframe_db15_pkg.sv
// Shared types and helpers for the DB15 serial pad reader.
//   db15_state_t : reader FSM states
//   frame_ticks  : ticks taken by one full frame (for benches and timing budgets)
//   cnt_width    : counter width able to hold 0..n-1 (never below 1 bit)
package jtframe_db15_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SHIFT_LO,
      ST_SHIFT_HI,
      ST_LATCH,
      ST_GAP
   } db15_state_t;

   function automatic int frame_ticks(input int players, input int bits,
                                      input int loadlen, input int gap);
      return 1 + loadlen + 2 * players * bits + 1 + gap;
   endfunction

   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/jtframe_db15_cen.sv
// Tick generator: free-running counter 0..DIV-1, one-clk tick on the last count.
// Reusable by any serial pad reader that needs a slow bit clock.
//   clk   : system clock
//   rst_n : asynchronous active-low reset (counter restarts at 0)
//   tick  : high for one clk every DIV clks
module jtframe_db15_cen
   import jtframe_db15_pkg::*;
#(
   parameter int DIV = 48
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int CW = cnt_width(DIV);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (r_cnt == CW'(DIV - 1)) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign tick = (r_cnt == CW'(DIV - 1));

endmodule

// File: rtl/jtframe_db15_multi.sv
// DB15 joystick adapter reader for any number of players x bits.
// Drives the adapter load/clock lines, shifts in the chain, debounces whole
// frames and flags controllers whose lines are all at the idle level.
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   en         : scanning enable, only looked at between frames
//   joy_clk    : adapter shift clock (registered)
//   joy_load   : adapter parallel-load strobe, high = load (registered)
//   joy_data   : adapter serial data, asynchronous to clk
//   joystick   : debounced buttons, player p bit b at [p*BITS+b], active-high
//   present    : controller p detected
//   frame_done : one-clk pulse when joystick/present are updated
//
// state       | meaning
// ST_IDLE     | lines low, waiting for a tick with en=1
// ST_LOAD     | joy_load high for LOADLEN ticks
// ST_SHIFT_LO | joy_clk low, sample data bit at end of tick
// ST_SHIFT_HI | joy_clk high, advance to next bit
// ST_LATCH    | debounce and commit the captured frame
// ST_GAP      | lines low for GAP ticks
module jtframe_db15_multi
   import jtframe_db15_pkg::*;
#(
   parameter int PLAYERS    = 2,
   parameter int BITS       = 16,
   parameter int DIV        = 48,
   parameter int LOADLEN    = 2,
   parameter int GAP        = 64,
   parameter int HOLD       = 2,
   parameter int ACTIVE_LOW = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      en,
   output logic                      joy_clk,
   output logic                      joy_load,
   input  logic                      joy_data,
   output logic [PLAYERS*BITS-1:0]   joystick,
   output logic [PLAYERS-1:0]        present,
   output logic                      frame_done
);

   localparam int   NB  = PLAYERS * BITS;
   localparam int   IW  = cnt_width(NB);
   localparam int   TW  = cnt_width((LOADLEN > GAP) ? LOADLEN : GAP);
   localparam int   SW  = $clog2(HOLD + 1);
   localparam logic POL = (ACTIVE_LOW != 0);

   db15_state_t        r_state;
   logic [IW-1:0]      r_idx;
   logic [TW-1:0]      r_tcnt;
   logic [NB-1:0]      r_cap;
   logic [NB-1:0]      r_prev;
   logic [SW-1:0]      r_stable;
   logic [1:0]         r_sync;
   logic               r_jclk;
   logic               r_load;
   logic [NB-1:0]      r_joy;
   logic [PLAYERS-1:0] r_present;
   logic               r_done;

   logic               w_tick;
   logic               w_bit;
   logic [SW-1:0]      w_stable_nxt;
   logic               w_commit;
   logic [NB-1:0]      w_joy;
   logic [PLAYERS-1:0] w_present;

   jtframe_db15_cen #(.DIV(DIV)) u_cen (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (w_tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[0], joy_data};
      end
   end

   assign w_bit = r_sync[1] ^ POL;

   always_comb begin
      w_stable_nxt = r_stable;
      if (r_cap != r_prev) begin
         w_stable_nxt = SW'(1);
      end else if (r_stable != SW'(HOLD)) begin
         w_stable_nxt = r_stable + 1'b1;
      end
   end

   assign w_commit = (w_stable_nxt == SW'(HOLD));

   // After polarity correction an absent player (all lines idle) reads as
   // all zeros, so presence is simply "any bit set" in its slice.
   always_comb begin
      w_joy     = '0;
      w_present = '0;
      for (int p = 0; p < PLAYERS; p++) begin
         w_present[p] = |r_cap[p*BITS +: BITS];
         if (w_present[p]) begin
            w_joy[p*BITS +: BITS] = r_cap[p*BITS +: BITS];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_idx     <= '0;
         r_tcnt    <= '0;
         r_cap     <= '0;
         r_prev    <= '0;
         r_stable  <= '0;
         r_jclk    <= 1'b0;
         r_load    <= 1'b0;
         r_joy     <= '0;
         r_present <= '0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_tick) begin
            case (r_state)
               ST_IDLE: begin
                  if (en) begin
                     r_state <= ST_LOAD;
                     r_load  <= 1'b1;
                     r_tcnt  <= '0;
                  end
               end
               ST_LOAD: begin
                  if (r_tcnt == TW'(LOADLEN - 1)) begin
                     r_state <= ST_SHIFT_LO;
                     r_load  <= 1'b0;
                     r_idx   <= '0;
                  end else begin
                     r_tcnt <= r_tcnt + 1'b1;
                  end
               end
               ST_SHIFT_LO: begin
                  r_cap[r_idx] <= w_bit;
                  r_jclk       <= 1'b1;
                  r_state      <= ST_SHIFT_HI;
               end
               ST_SHIFT_HI: begin
                  r_jclk <= 1'b0;
                  if (r_idx == IW'(NB - 1)) begin
                     r_state <= ST_LATCH;
                  end else begin
                     r_idx   <= r_idx + 1'b1;
                     r_state <= ST_SHIFT_LO;
                  end
               end
               ST_LATCH: begin
                  r_prev   <= r_cap;
                  r_stable <= w_stable_nxt;
                  if (w_commit) begin
                     r_joy     <= w_joy;
                     r_present <= w_present;
                     r_done    <= 1'b1;
                  end
                  r_tcnt  <= '0;
                  r_state <= ST_GAP;
               end
               ST_GAP: begin
                  if (r_tcnt == TW'(GAP - 1)) begin
                     r_state <= ST_IDLE;
                  end else begin
                     r_tcnt <= r_tcnt + 1'b1;
                  end
               end
               default: begin
                  r_state <= ST_IDLE;
                  r_jclk  <= 1'b0;
                  r_load  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign joy_clk    = r_jclk;
   assign joy_load   = r_load;
   assign joystick   = r_joy;
   assign present    = r_present;
   assign frame_done = r_done;

endmodule

// File: tb/tb_jtframe_db15_multi.sv
// Bench for jtframe_db15_multi: an adapter model feeds raw frames, and a
// frame-history reference model predicts commits and decoded outputs.
module tb_jtframe_db15_multi;

   localparam int PLAYERS     = 2;
   localparam int BITS        = 16;
   localparam int DIV         = 8;
   localparam int LOADLEN     = 2;
   localparam int GAP         = 16;
   localparam int HOLD        = 2;
   localparam int ACTIVE_LOW  = 1;
   localparam int NB          = PLAYERS * BITS;
   localparam int FRAME_TICKS = 1 + LOADLEN + 2 * NB + 1 + GAP;
   localparam int FRAME_CLK   = FRAME_TICKS * DIV;
   localparam bit AL          = 1'b1;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              en = 1'b0;
   logic              joy_clk;
   logic              joy_load;
   logic              joy_data = 1'b1;
   logic [NB-1:0]     joystick;
   logic [PLAYERS-1:0] present;
   logic              frame_done;

   int checks = 0;
   int errors = 0;

   logic [NB-1:0]      raw_frame = '1;
   logic [NB-1:0]      raw_cur = '1;
   int                 sh_k = 0;

   logic [NB-1:0]      hist[$];
   logic [NB-1:0]      exp_joy = '0;
   logic [PLAYERS-1:0] exp_pres = '0;
   int                 exp_done = 0;

   jtframe_db15_multi #(
      .PLAYERS(PLAYERS), .BITS(BITS), .DIV(DIV), .LOADLEN(LOADLEN),
      .GAP(GAP), .HOLD(HOLD), .ACTIVE_LOW(ACTIVE_LOW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .joy_clk    (joy_clk),
      .joy_load   (joy_load),
      .joy_data   (joy_data),
      .joystick   (joystick),
      .present    (present),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   // Adapter: parallel-load on joy_load, next bit on each joy_clk rise,
   // line floats high once the chain is exhausted.
   always @(posedge joy_load or posedge joy_clk) begin
      if (joy_load) begin
         raw_cur = raw_frame;
         sh_k = 0;
      end else begin
         sh_k++;
      end
      joy_data = (sh_k < NB) ? raw_cur[sh_k] : 1'b1;
   end

   // Commit when the last HOLD captured frames are identical.
   function automatic void update_model();
      int n;
      bit same;
      logic [BITS-1:0] raw_s;
      n = hist.size();
      same = (n >= HOLD);
      exp_done = 0;
      for (int i = 1; i < HOLD; i++) begin
         if (same && hist[n-1-i] !== hist[n-1]) same = 0;
      end
      if (same) begin
         exp_done = 1;
         for (int p = 0; p < PLAYERS; p++) begin
            raw_s = hist[n-1][p*BITS +: BITS];
            exp_pres[p] = (raw_s != {BITS{AL}});
            exp_joy[p*BITS +: BITS] = exp_pres[p] ? (AL ? ~raw_s : raw_s) : '0;
         end
      end
   endfunction

   task automatic apply_reset();
      en = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      hist.delete();
      exp_joy = '0;
      exp_pres = '0;
      exp_done = 0;
   endtask

   // Runs one frame with the given raw pattern; returns frame_done activity.
   task automatic run_frame(input logic [NB-1:0] raw, output int done_hi,
                            output int done_pulses, output bit ok,
                            output int start_cyc, output bit clk_before);
      bit started;
      int falls;
      int tail;
      logic pl, pc, pd;
      raw_frame = raw;
      done_hi = 0; done_pulses = 0; ok = 0; start_cyc = -1; clk_before = 0;
      started = 0; falls = 0; tail = -1;
      pl = joy_load; pc = joy_clk; pd = frame_done;
      for (int c = 1; c <= 2 * FRAME_CLK + 4 * DIV; c++) begin
         @(negedge clk);
         if (!started && joy_clk) clk_before = 1;
         if (!started && joy_load && !pl) begin
            started = 1;
            start_cyc = c;
         end
         if (started && !joy_clk && pc) falls++;
         if (frame_done) done_hi++;
         if (frame_done && !pd) done_pulses++;
         pl = joy_load; pc = joy_clk; pd = frame_done;
         if (tail >= 0) begin
            tail++;
            if (tail > DIV + 3) begin
               ok = 1;
               break;
            end
         end
         if (started && falls == NB && tail < 0) tail = 0;
      end
      if (ok) hist.push_back(raw);
   endtask

   task automatic test_reset();
      int busy;
      rst_n = 1'b0;
      en = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if ({joy_clk, joy_load, frame_done} !== 3'b000) begin
         errors++;
         $display("FAIL reset_lines: got clk/load/done=%b expected 000", {joy_clk, joy_load, frame_done});
      end
      checks++;
      if ({present, joystick} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got present=%b joystick=%h expected 0", present, joystick);
      end
      rst_n = 1'b1;
      busy = 0;
      for (int c = 0; c < 4 * DIV; c++) begin
         @(negedge clk);
         if (joy_clk || joy_load || frame_done) busy++;
      end
      checks++;
      if (busy !== 0) begin
         errors++;
         $display("FAIL idle_without_en: got %0d active cycles expected 0", busy);
      end
   endtask

   task automatic test_frame_timing();
      int load_rise[$];
      int jrise[$];
      int widths[$];
      int load_hi, overlap, hi_cnt, bad_w, bad_p;
      logic pl, pc;
      apply_reset();
      raw_frame = $urandom();
      en = 1'b1;
      load_hi = 0; overlap = 0; hi_cnt = 0; bad_w = 0; bad_p = 0;
      pl = joy_load; pc = joy_clk;
      for (int c = 1; c <= 3 * FRAME_CLK; c++) begin
         @(negedge clk);
         if (joy_load && !pl) load_rise.push_back(c);
         if (load_rise.size() >= 2) break;
         if (joy_load && joy_clk) overlap++;
         if (load_rise.size() == 1) begin
            if (joy_load) load_hi++;
            if (joy_clk && !pc) jrise.push_back(c);
            if (joy_clk) hi_cnt++;
            if (!joy_clk && pc) begin
               widths.push_back(hi_cnt);
               hi_cnt = 0;
            end
         end
         pl = joy_load; pc = joy_clk;
      end
      foreach (widths[i]) if (widths[i] != DIV) bad_w++;
      for (int i = 1; i < jrise.size(); i++) if (jrise[i] - jrise[i-1] != 2 * DIV) bad_p++;
      checks++;
      if (load_rise.size() !== 2) begin
         errors++;
         $display("FAIL timing_two_frames: got %0d load rises expected 2", load_rise.size());
      end
      checks++;
      if (load_hi !== LOADLEN * DIV) begin
         errors++;
         $display("FAIL timing_load_len: got %0d clk expected %0d", load_hi, LOADLEN * DIV);
      end
      checks++;
      if (jrise.size() !== NB || widths.size() !== NB) begin
         errors++;
         $display("FAIL timing_pulse_count: got %0d rises %0d falls expected %0d", jrise.size(), widths.size(), NB);
      end
      checks++;
      if (bad_w !== 0 || bad_p !== 0) begin
         errors++;
         $display("FAIL timing_pulse_shape: got %0d bad widths %0d bad periods expected 0", bad_w, bad_p);
      end
      checks++;
      if (load_rise.size() == 2 && load_rise[1] - load_rise[0] !== FRAME_CLK) begin
         errors++;
         $display("FAIL timing_frame_period: got %0d clk expected %0d", load_rise[1] - load_rise[0], FRAME_CLK);
      end
      checks++;
      if (overlap !== 0) begin
         errors++;
         $display("FAIL timing_overlap: got %0d cycles with load and clk high expected 0", overlap);
      end
   endtask

   task automatic test_decode();
      int dh, dp, sc;
      bit ok, cb;
      apply_reset();
      en = 1'b1;
      for (int f = 0; f < 2; f++) begin
         run_frame({16'h7FFF, 16'hFFFE}, dh, dp, ok, sc, cb);
         update_model();
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL decode_timeout: frame %0d did not complete", f);
         end
         checks++;
         if (dh !== exp_done || dp !== exp_done) begin
            errors++;
            $display("FAIL decode_done: got %0d high cycles %0d pulses expected %0d", dh, dp, exp_done);
         end
         checks++;
         if (joystick !== exp_joy || present !== exp_pres) begin
            errors++;
            $display("FAIL decode_out: got %h/%b expected %h/%b", joystick, present, exp_joy, exp_pres);
         end
      end
      checks++;
      if (joystick !== 32'h8000_0001 || present !== 2'b11) begin
         errors++;
         $display("FAIL decode_value: got %h/%b expected 80000001/11", joystick, present);
      end
   endtask

   task automatic test_absent();
      int dh, dp, sc;
      bit ok, cb;
      for (int f = 0; f < 3; f++) begin
         run_frame({16'hFFFF, 16'hFFDB}, dh, dp, ok, sc, cb);
         update_model();
         checks++;
         if (!ok || dh !== exp_done || dp !== exp_done) begin
            errors++;
            $display("FAIL absent_done: got ok=%0d done=%0d expected %0d", ok, dh, exp_done);
         end
         checks++;
         if (joystick !== exp_joy || present !== exp_pres) begin
            errors++;
            $display("FAIL absent_out: got %h/%b expected %h/%b", joystick, present, exp_joy, exp_pres);
         end
      end
      checks++;
      if (present !== 2'b01 || joystick !== 32'h0000_0024) begin
         errors++;
         $display("FAIL absent_value: got %h/%b expected 00000024/01", joystick, present);
      end
   endtask

   task automatic test_debounce();
      logic [NB-1:0] a, b, held;
      int dh, dp, sc, done_total;
      bit ok, cb;
      a = {16'hEFFF, 16'hFF7E};
      b = a ^ 32'h0000_0008;
      for (int f = 0; f < 2; f++) begin
         run_frame(a, dh, dp, ok, sc, cb);
         update_model();
      end
      checks++;
      if (joystick !== exp_joy || dh !== 1) begin
         errors++;
         $display("FAIL debounce_base: got %h done=%0d expected %h done=1", joystick, dh, exp_joy);
      end
      held = joystick;
      done_total = 0;
      for (int f = 0; f < 5; f++) begin
         run_frame((f % 2 == 0) ? b : a, dh, dp, ok, sc, cb);
         update_model();
         done_total += dh;
         checks++;
         if (joystick !== held || exp_done !== 0 || !ok) begin
            errors++;
            $display("FAIL debounce_toggle: got %h ok=%0d expected %h held", joystick, ok, held);
         end
      end
      checks++;
      if (done_total !== 0) begin
         errors++;
         $display("FAIL debounce_no_done: got %0d done cycles expected 0", done_total);
      end
      run_frame(b, dh, dp, ok, sc, cb);
      update_model();
      checks++;
      if (joystick !== exp_joy || joystick[3] !== 1'b1 || dh !== 1) begin
         errors++;
         $display("FAIL debounce_commit: got %h done=%0d expected %h done=1", joystick, dh, exp_joy);
      end
   endtask

   task automatic test_random();
      logic [NB-1:0] pool[3];
      logic [NB-1:0] v;
      int dh, dp, sc, reps;
      bit ok, cb;
      pool[0] = $urandom();
      pool[1] = {$urandom_range(0, 65535) , 16'hFFFF};
      pool[2] = {16'hFFFF, 16'($urandom_range(0, 65535))};
      for (int g = 0; g < 7; g++) begin
         v = pool[$urandom_range(0, 2)];
         reps = $urandom_range(1, 3);
         for (int r = 0; r < reps; r++) begin
            run_frame(v, dh, dp, ok, sc, cb);
            update_model();
            checks++;
            if (!ok || dh !== exp_done || dp !== exp_done) begin
               errors++;
               $display("FAIL random_done: got ok=%0d done=%0d/%0d expected %0d", ok, dh, dp, exp_done);
            end
            checks++;
            if (joystick !== exp_joy || present !== exp_pres) begin
               errors++;
               $display("FAIL random_out: raw %h got %h/%b expected %h/%b", v, joystick, present, exp_joy, exp_pres);
            end
         end
      end
   endtask

   task automatic test_en_drop();
      logic [NB-1:0] v;
      int dh, dp, sc, rises, falls, tail, busy, wait_c;
      bit ok, cb, started, seen;
      logic pl, pc;
      v = {16'hF0F0, 16'h0FF0};
      en = 1'b1;
      run_frame(v, dh, dp, ok, sc, cb);
      update_model();
      raw_frame = v;
      started = 0; rises = 0; falls = 0; tail = -1; dh = 0; ok = 0;
      pl = joy_load; pc = joy_clk;
      for (int c = 0; c < 2 * FRAME_CLK + 4 * DIV; c++) begin
         @(negedge clk);
         if (!started && joy_load && !pl) started = 1;
         if (started && joy_clk && !pc) begin
            rises++;
            if (rises == 10) en = 1'b0;
         end
         if (started && !joy_clk && pc) falls++;
         if (frame_done) dh++;
         pl = joy_load; pc = joy_clk;
         if (tail >= 0) begin
            tail++;
            if (tail > DIV + 3) begin
               ok = 1;
               break;
            end
         end
         if (started && falls == NB && tail < 0) tail = 0;
      end
      if (ok) hist.push_back(v);
      update_model();
      checks++;
      if (!ok || rises !== NB || en !== 1'b0) begin
         errors++;
         $display("FAIL en_drop_finish: got ok=%0d rises=%0d expected frame of %0d", ok, rises, NB);
      end
      checks++;
      if (dh !== exp_done) begin
         errors++;
         $display("FAIL en_drop_commit: got %0d done cycles expected %0d", dh, exp_done);
      end
      busy = 0;
      for (int c = 0; c < 2 * FRAME_CLK; c++) begin
         @(negedge clk);
         if (joy_load || joy_clk || frame_done) busy++;
      end
      checks++;
      if (busy !== 0) begin
         errors++;
         $display("FAIL en_drop_parked: got %0d active cycles expected 0", busy);
      end
      checks++;
      if (joystick !== exp_joy || present !== exp_pres) begin
         errors++;
         $display("FAIL en_drop_hold: got %h/%b expected %h/%b", joystick, present, exp_joy, exp_pres);
      end
      en = 1'b1;
      seen = 0; wait_c = 0;
      for (int c = 1; c <= 3 * DIV; c++) begin
         @(negedge clk);
         if (joy_load) begin
            seen = 1;
            wait_c = c;
            break;
         end
      end
      checks++;
      if (!seen || wait_c > DIV) begin
         errors++;
         $display("FAIL en_restart: got load after %0d clk (seen=%0d) expected within %0d", wait_c, seen, DIV);
      end
   endtask

   task automatic test_reset_mid();
      logic [NB-1:0] x;
      int dh, dp, sc;
      bit ok, cb, found;
      x = {16'hFDFF, 16'hBFFF};
      apply_reset();
      en = 1'b1;
      for (int f = 0; f < 2; f++) begin
         run_frame(x, dh, dp, ok, sc, cb);
         update_model();
      end
      checks++;
      if (joystick !== exp_joy || present !== exp_pres || dh !== 1) begin
         errors++;
         $display("FAIL rstmid_pre: got %h/%b done=%0d expected %h/%b done=1", joystick, present, dh, exp_joy, exp_pres);
      end
      found = 0;
      for (int c = 0; c < FRAME_CLK; c++) begin
         @(posedge clk);
         #1;
         if (joy_clk) begin
            found = 1;
            break;
         end
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (!found || {joy_clk, joy_load, present, joystick} !== '0) begin
         errors++;
         $display("FAIL rstmid_async: found=%0d got clk=%b load=%b %h/%b expected all 0", found, joy_clk, joy_load, joystick, present);
      end
      repeat (3) @(negedge clk);
      hist.delete();
      exp_joy = '0;
      exp_pres = '0;
      rst_n = 1'b1;
      run_frame(x, dh, dp, ok, sc, cb);
      update_model();
      checks++;
      if (!ok || cb || sc < 1 || sc > DIV) begin
         errors++;
         $display("FAIL rstmid_restart: got ok=%0d clk_before=%0d load after %0d clk expected load within %0d", ok, cb, sc, DIV);
      end
      checks++;
      if (dh !== 0 || joystick !== '0 || present !== '0) begin
         errors++;
         $display("FAIL rstmid_stale: got done=%0d %h/%b expected no commit", dh, joystick, present);
      end
      run_frame(x, dh, dp, ok, sc, cb);
      update_model();
      checks++;
      if (dh !== exp_done || joystick !== exp_joy || present !== exp_pres) begin
         errors++;
         $display("FAIL rstmid_recommit: got done=%0d %h/%b expected %0d %h/%b", dh, joystick, present, exp_done, exp_joy, exp_pres);
      end
   endtask

   initial begin
      test_reset();
      test_frame_timing();
      test_decode();
      test_absent();
      test_debounce();
      test_random();
      test_en_drop();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
